// File: rtl/pooled_map_writer_if.sv
// pooled_map_writer_if: pooled-stream input, memory write port and status of pooled_map_writer.
// slave : the writer (consumes Clear/Data_In/Valid_In/Wr_Ready, drives the write port and status)
// master: the surrounding logic (drives inputs, observes the write port and status)
interface pooled_map_writer_if #(
  parameter int DATA_WIDHT = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  Clear;
  logic [DATA_WIDHT-1:0] Data_In;
  logic                  Valid_In;
  logic [DATA_WIDHT-1:0] Wr_Data;
  logic [ADDR_WIDTH-1:0] Wr_Addr;
  logic                  Wr_Valid;
  logic                  Wr_Ready;
  logic                  Wr_Last;
  logic                  Frame_Done;
  logic                  Overflow;
  logic                  Busy;
  modport slave (
    input  Clear, Data_In, Valid_In, Wr_Ready,
    output Wr_Data, Wr_Addr, Wr_Valid, Wr_Last, Frame_Done, Overflow, Busy
  );
  modport master (
    output Clear, Data_In, Valid_In, Wr_Ready,
    input  Wr_Data, Wr_Addr, Wr_Valid, Wr_Last, Frame_Done, Overflow, Busy
  );
endinterface

// File: rtl/pooled_map_writer.sv
// pooled_map_writer: buffers the pooled feature-map stream and writes it to memory at linear addresses.
// clk : rising-edge clock
// rst : asynchronous active-low reset
// bus : pooled_map_writer_if.slave -- Clear, Data_In/Valid_In in; Wr_* write port; Frame_Done/Overflow/Busy status
module pooled_map_writer #(
  parameter int DATA_WIDHT = 32,
  parameter int OUT_WIDHT  = 149,
  parameter int OUT_HEIGHT = 149,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input logic clk,
  input logic rst,
  pooled_map_writer_if.slave bus
);
  localparam int TOTAL = OUT_WIDHT * OUT_HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] TOT  = CW'(TOTAL);
  localparam logic [CW-1:0] TOT1 = CW'(TOTAL - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;
  state_t                state_q, state_d;
  logic [PW:0]           wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]         in_q, in_d, out_q, out_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDHT-1:0] mem_q [FIFO_DEPTH];
  logic                  empty, full, rd, wr, last, open_s, restart;
  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    empty   = wp_q == rp_q;
    full    = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
    rd      = !empty && bus.Wr_Ready;
    last    = !empty && (out_q == TOT1);
    open_s  = (state_q == IDLE) || (state_q == ACTIVE);
    wr      = !bus.Clear && bus.Valid_In && open_s && (!full || rd);
    restart = bus.Clear || (state_q == DONE);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACTIVE: if (wr) state_d = (in_q + CW'(1) == TOT) ? FLUSH : ACTIVE;
      FLUSH:        if (rd && last) state_d = DONE;
      default:      state_d = IDLE;
    endcase
    if (bus.Clear) state_d = IDLE;
  end
  // out_q stops at TOTAL-1 on the final handshake; DONE then clears it.
  always_comb begin
    in_d  = restart ? '0 : wr ? in_q + CW'(1) : in_q;
    out_d = restart ? '0 : (rd && !last) ? out_q + CW'(1) : out_q;
    wp_d  = bus.Clear ? '0 : wr ? wp_q + (PW+1)'(1) : wp_q;
    rp_d  = bus.Clear ? '0 : rd ? rp_q + (PW+1)'(1) : rp_q;
    ovf_d = !bus.Clear && (ovf_q || (bus.Valid_In && !wr));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      in_q    <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      in_q    <= in_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[wp_q[PW-1:0]] <= bus.Data_In;
    end
  end
  assign bus.Wr_Data    = mem_q[rp_q[PW-1:0]];
  assign bus.Wr_Addr    = ADDR_WIDTH'(BASE_ADDR + int'(out_q));
  assign bus.Wr_Valid   = !empty;
  assign bus.Wr_Last    = last;
  assign bus.Frame_Done = state_q == DONE;
  assign bus.Overflow   = ovf_q;
  assign bus.Busy       = state_q != IDLE;
endmodule

// File: doc/pooled_map_writer.md
# pooled_map_writer

Downstream stage of the 2x2 max-pooling block. It accepts the pooled feature-map stream (one 32-bit word per `Valid_In` pulse, no backpressure possible), buffers it in a small FIFO, and writes it to feature-map memory through a valid/ready port with linear addresses. It also counts pooled elements, flags the last word of a frame, and reports frame completion and input overflow.

## Interface
- `DATA_WIDHT`, 32: word width.
- `OUT_WIDHT`, 149: pooled map width (elements per row).
- `OUT_HEIGHT`, 149: pooled map height (rows).
- `FIFO_DEPTH`, 8: buffer entries; a power of 2 and at least 2.
- `ADDR_WIDTH`, 16: write address width; must hold `BASE_ADDR + OUT_WIDHT*OUT_HEIGHT - 1`.
- `BASE_ADDR`, 0: address of element (0,0).

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `Clear` input 1: synchronous clear; aborts the frame, empties the FIFO, clears `Overflow`.
- `Data_In` input DATA_WIDHT: pooled word.
- `Valid_In` input 1: `Data_In` is valid this cycle.
- `Wr_Data` output DATA_WIDHT: memory write data.
- `Wr_Addr` output ADDR_WIDTH: memory write address.
- `Wr_Valid` output 1: write request.
- `Wr_Ready` input 1: memory accepts the write this cycle.
- `Wr_Last` output 1: current write is the final element of the frame.
- `Frame_Done` output 1: one-cycle pulse when the frame is fully written.
- `Overflow` output 1: sticky flag; an input word was dropped.
- `Busy` output 1: a frame is in progress (state is not IDLE).

## Operation
- `TOTAL` = `OUT_WIDHT*OUT_HEIGHT`.
- **Counters:**
  - `in_cnt` counts accepted input words, 0 to `TOTAL`.
  - `out_cnt` counts write handshakes, 0 to `TOTAL-1`.
- **FIFO:**
  - Show-ahead: `Wr_Data` is the head entry.
  - `Wr_Valid` equals "FIFO not empty".
  - Read fires on `Wr_Valid & Wr_Ready`.
- **Write acceptance:** a write is accepted when `Valid_In` is high, the state is IDLE or ACTIVE, and either the FIFO is not full or a read fires in the same cycle.
- **Overflow:** set when `Valid_In` arrives and the FIFO is full with no read that cycle, or when `Valid_In` arrives in FLUSH or DONE. The word is dropped and `in_cnt` does not increment.
- **Addressing:**
  - `Wr_Addr` = `BASE_ADDR + out_cnt`, with the sum truncated to ADDR_WIDTH.
  - `Wr_Last` = `Wr_Valid & (out_cnt == TOTAL-1)`.
- **FSM states:**
  - **IDLE:** an accepted word moves to ACTIVE. If `TOTAL` is 1, that word moves directly to FLUSH.
  - **ACTIVE:** the accepted word that makes `in_cnt` equal `TOTAL` moves to FLUSH.
  - **FLUSH:** the handshake with `Wr_Last` high moves to DONE.
  - **DONE:** `Frame_Done` is 1 for this single cycle. Next state is IDLE, and both counters clear to 0.
- **Clear:**
  - Takes priority over every other event in the same cycle.
  - Next state is IDLE; FIFO pointers, both counters and `Overflow` go to 0.
  - An input presented in that cycle is discarded and does not set `Overflow`.
- **Simultaneous read and write when full:** both take effect and the occupancy is unchanged.
- **Simultaneous read and write when empty:** the word is written; `Wr_Valid` rises next cycle (no bypass).

## Timing
- **Reset values:**
  - `Wr_Valid`, `Wr_Last`, `Frame_Done`, `Overflow` and `Busy` are 0.
  - `Wr_Addr` is `BASE_ADDR`.
  - `Wr_Data` is 0 (FIFO storage reset to 0).
  - State is IDLE.
- **Reset mid-frame:** asynchronous assertion forces all of the above immediately, regardless of clock.
- **Latency:** a word accepted at edge N appears on `Wr_Data` with `Wr_Valid` high after edge N, provided the FIFO was empty.
- **Handshake:**
  - `Wr_Data`, `Wr_Addr` and `Wr_Last` are held stable while `Wr_Valid & !Wr_Ready`.
  - The next entry appears in the cycle after the handshake.
- **Frame completion:** `Frame_Done` is high in the cycle after the last handshake; `Busy` drops the cycle after that.
- **Throughput:** one word per cycle sustained when `Wr_Ready` is held high.

## Test plan
Parameters for all scenarios: `OUT_WIDHT`=3, `OUT_HEIGHT`=2, `FIFO_DEPTH`=4, `BASE_ADDR`=0x100.
- **Streaming, ready held high:**
  - Stimulus: 6 back-to-back words 0xA0 to 0xA5.
  - Required: writes of 0xA0 to 0xA5 at addresses 0x100 to 0x105, each one cycle after input; `Wr_Last` only on 0x105.
  - Required: `Frame_Done` pulses once, one cycle after the last handshake; `Overflow` stays 0.
- **Backpressure:**
  - Stimulus: `Wr_Ready`=0 for 4 cycles while 4 words arrive, then `Wr_Ready`=1, then 2 more words.
  - Required: `Wr_Data`/`Wr_Addr` hold at 0xA0/0x100 while stalled; all 6 words are written in order; no overflow.
- **Overflow:**
  - Stimulus: `Wr_Ready`=0 and 5 words arrive.
  - Required: the 5th word is dropped and `Overflow`=1, sticky.
  - Required: after `Wr_Ready`=1, only 4 writes (0x100 to 0x103) occur and the frame remains in ACTIVE.
- **Full with simultaneous read:**
  - Stimulus: FIFO full, `Valid_In` and `Wr_Ready` both high in the same cycle.
  - Required: the word is accepted, occupancy stays 4, `Overflow` stays 0.
- **Extra input during FLUSH:**
  - Stimulus: after the 6th word, send a 7th while `Wr_Ready`=0.
  - Required: the 7th word is dropped and `Overflow`=1; the frame still completes with 6 writes.
- **Clear and reset mid-frame:**
  - Stimulus: after 3 writes, pulse `Clear`; separately, assert `rst` mid-frame.
  - Required (Clear): `Busy`=0, `Wr_Valid`=0, `Overflow`=0; the next frame starts at 0x100.
  - Required (reset): outputs go to reset values immediately, without waiting for a clock edge.
